tt_sweep_checker: RTL and testbench
===================================

// Module: tt_sweep_checker
// PURPOSE
//  Response-side counterpart of the combinational truth-table benches.
//  - Sweeps every N_IN-bit input vector into a combinational DUT.
//  - Samples the DUT outputs and compares them with a packed expected truth table.
//  - Reports a mismatch count, the first failing vector and a pass flag.
//  - Sits beside the DUT in a clocked harness and replaces hand-read $monitor tables.
// PARAMETERS
//  N_IN    3      DUT input width; the sweep covers vectors 0 .. 2**N_IN-1
//  N_OUT   2      DUT output width
//  SETTLE  1      wait cycles between driving a vector and sampling (0..15)
//  EXP     {8'hF0,8'hCD}  N_OUT*2**N_IN bits; slice [o*2**N_IN +: 2**N_IN] = column o,
//                 bit i = expected output o for vector i (i = {a,b,c}, a = MSB)
// PORTS
//  clk            in   1          rising-edge clock
//  rst_n          in   1          asynchronous active-low reset
//  start          in   1          request a sweep; sampled only in IDLE or DONE
//  vec_o          out  N_IN       registered stimulus vector to the DUT
//  dut_i          in   N_OUT      DUT outputs (bit o = output o)
//  busy           out  1          high while a sweep runs
//  done           out  1          high from sweep end until the next start
//  pass           out  1          valid when done; 1 iff err_cnt == 0
//  err_cnt        out  N_IN+1     number of failing vectors (any output bit wrong)
//  first_fail     out  N_IN       index of the first failing vector; 0 if none
//  fail_map       out  2**N_IN    per-vector fail bits (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE. All outputs 0:
//    vec_o, busy, done, pass, err_cnt, first_fail, fail_map.
//  - FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
//  - IDLE/DONE, start=1: clear err_cnt, first_fail and fail_map; idx=0; busy=1;
//    done=0; pass=0; go to DRIVE.
//  - DRIVE (1 cycle): vec_o<=idx; wait counter<=SETTLE. Next state is WAIT,
//    or SAMPLE if SETTLE==0.
//  - WAIT: decrement the counter each cycle; go to SAMPLE when it reaches 1.
//    Total SETTLE cycles in WAIT.
//  - SAMPLE (1 cycle): mismatch = (dut_i != expected column bits at idx).
//    On mismatch: err_cnt++; if err_cnt was 0, first_fail<=idx.
//    If idx == 2**N_IN-1: go to DONE; busy=0, done=1, pass=(final err_cnt==0).
//    Otherwise idx++ and go to DRIVE.
//  - Per-vector cost is SETTLE+2 cycles. done rises 2**N_IN*(SETTLE+2) cycles after
//    the start-accept edge (24 cycles at the defaults).
//  - vec_o holds its value through WAIT/SAMPLE and holds the last vector in DONE.
//  - start while busy is ignored; the running sweep is not restarted.
//  - err_cnt saturates at 2**N_IN. It cannot overflow: width is N_IN+1.
//  - idx wraps only by the explicit SAMPLE→DONE exit and never counts past 2**N_IN-1.
//  - rst_n low mid-sweep: immediate return to the reset values; the partial result
//    is discarded.
//  - dut_i is treated as combinational from vec_o. No synchroniser.
// CONFIGURATION
//  TT_FAILMAP_EN defined:
//   - In SAMPLE, fail_map[idx]<=mismatch.
//   - fail_map is cleared on start and on reset, and held in DONE.
//  TT_FAILMAP_EN undefined:
//   - fail_map is tied to 0.
//   - No per-vector storage is built; all other behaviour is identical.
// TESTING
//  T1 DUT=f_a/f_b models, defaults, start pulse -> done after 24 clk,
//     pass=1, err_cnt=0, first_fail=0, fail_map=8'h00.
//  T2 dut_i[0] stuck at 0 -> err_cnt=5, first_fail=0, pass=0,
//     fail_map=8'hCD (with TT_FAILMAP_EN).
//  T3 dut_i[1] inverted -> err_cnt=8, first_fail=0, pass=0, fail_map=8'hFF.
//  T4 start pulsed again at cycle 10 of a sweep -> ignored; done still at cycle 24.
//  T5 rst_n low at cycle 12, release, start -> all outputs 0 during reset;
//     the fresh sweep gives T1 results.
//  T6 SETTLE=0, correct DUT -> done after 16 clk, pass=1; restart from DONE
//     clears err_cnt first.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Clocked response checker: sweeps every input vector of a combinational DUT and compares its outputs against a packed truth table.
// Optional per-vector fail map is built only when TT_FAILMAP_EN is defined; otherwise fail_map is tied to 0.
module tt_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXP = {8'hF0, 8'hCD}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec_o,
  input  logic [N_OUT-1:0]  dut_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic [N_IN-1:0]   first_fail,
  output logic [2**N_IN-1:0] fail_map
);

  localparam int              NV   = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = '1;
  localparam logic [N_IN:0]   ERR_MAX = (N_IN+1)'(NV);
  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic [N_OUT-1:0] exp_col;
  logic            mismatch;
`ifdef TT_FAILMAP_EN
  logic [NV-1:0]   fm_q, fm_d;
`endif

  function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  // Expected output bits for the vector currently on the DUT.
  always_comb begin
    exp_col = '0;
    for (int o = 0; o < N_OUT; o++) begin
      exp_col[o] = EXP[o*NV + int'(idx_q)];
    end
  end

  assign mismatch = (dut_i != exp_col);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
`ifdef TT_FAILMAP_EN
    fm_d    = fm_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d   = '0;
          ff_d    = '0;
`ifdef TT_FAILMAP_EN
          fm_d    = '0;
`endif
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        vec_d   = idx_q;
        wcnt_d  = SETTLE_W;
        state_d = (SETTLE_W == 4'd0) ? S_SAMPLE : S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q <= 4'd1) begin
          wcnt_d  = 4'd0;
          state_d = S_SAMPLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = sat_inc(err_q);
          if (err_q == '0) ff_d = idx_q;
        end
`ifdef TT_FAILMAP_EN
        fm_d[idx_q] = mismatch;
`endif
        // The final vector exits to DONE; idx never advances past LAST.
        if (idx_q == LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

`ifdef TT_FAILMAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fm_q <= '0;
    else        fm_q <= fm_d;
  end
  assign fail_map = fm_q;
`else
  assign fail_map = '0;
`endif

  assign vec_o      = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: two instances (SETTLE=1 and SETTLE=0) checking modelled DUTs, with fault modes.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, start_b;
  logic [2:0] vec_a, vec_b, ff_a, ff_b;
  logic [1:0] dut_a, dut_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] err_a, err_b;
  logic [7:0] fm_a, fm_b;
  int         mode_a, mode_b;
  int         tests = 0;
  int         fails = 0;

`ifdef TT_FAILMAP_EN
  localparam bit FM_EN = 1'b1;
`else
  localparam bit FM_EN = 1'b0;
`endif

  // f0 = b | (~a & ~c)  (column 8'hCD), f1 = a  (column 8'hF0); mode 1: out0 stuck 0, mode 2: out1 inverted.
  function automatic logic [1:0] model(input logic [2:0] v, input int mode);
    logic a, b, c, f0, f1;
    a  = v[2];
    b  = v[1];
    c  = v[0];
    f0 = b | (~a & ~c);
    f1 = a;
    if (mode == 1) f0 = 1'b0;
    if (mode == 2) f1 = ~f1;
    return {f1, f0};
  endfunction

  assign dut_a = model(vec_a, mode_a);
  assign dut_b = model(vec_b, mode_b);

  tt_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_o(vec_a), .dut_i(dut_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail(ff_a), .fail_map(fm_a)
  );

  tt_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_o(vec_b), .dut_i(dut_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail(ff_b), .fail_map(fm_b)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_vec"},  32'(vec_a),  0);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_done"}, 32'(done_a), 0);
    check({tag, "_pass"}, 32'(pass_a), 0);
    check({tag, "_err"},  32'(err_a),  0);
    check({tag, "_ff"},   32'(ff_a),   0);
    check({tag, "_fm"},   32'(fm_a),   0);
  endtask

  // Pulse start, then count cycles from the accept edge until done rises.
  task automatic run(input bit b, input int exp_cycles, input int restart_at, input string tag);
    int   n;
    int   per;
    logic d;
    per = b ? 2 : 3;
    @(negedge clk);
    start_a = !b;
    start_b = b;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    n = 0;
    check({tag, "_busy_acc"}, 32'(b ? busy_b : busy_a), 1);
    check({tag, "_err_clr"},  32'(b ? err_b : err_a), 0);
    check({tag, "_done_clr"}, 32'(b ? done_b : done_a), 0);
    d = 1'b0;
    while (!d && n < 500) begin
      @(negedge clk);
      n++;
      start_a = !b && (n == restart_at);
      start_b = b && (n == restart_at);
      d = b ? done_b : done_a;
      if (n == per + 1) check({tag, "_vec1"}, 32'(b ? vec_b : vec_a), 1);
      if (n == exp_cycles - 1) check({tag, "_early"}, 32'(d), 0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, "_busy_end"}, 32'(b ? busy_b : busy_a), 0);
    check({tag, "_vec_last"}, 32'(b ? vec_b : vec_a), 7);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = 0;
    mode_b  = 0;
    #12;
    check_zero_a("RST");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: correct DUT
    run(1'b0, 24, -1, "T1");
    check("T1_pass", 32'(pass_a), 1);
    check("T1_err",  32'(err_a),  0);
    check("T1_ff",   32'(ff_a),   0);
    check("T1_fm",   32'(fm_a),   0);

    // T2: out0 stuck at 0 -> fails wherever column 0 (CD) is 1
    mode_a = 1;
    run(1'b0, 24, -1, "T2");
    check("T2_pass", 32'(pass_a), 0);
    check("T2_err",  32'(err_a),  5);
    check("T2_ff",   32'(ff_a),   0);
    check("T2_fm",   32'(fm_a),   FM_EN ? 32'hCD : 32'h0);

    // T3: out1 inverted -> every vector fails
    mode_a = 2;
    run(1'b0, 24, -1, "T3");
    check("T3_pass", 32'(pass_a), 0);
    check("T3_err",  32'(err_a),  8);
    check("T3_ff",   32'(ff_a),   0);
    check("T3_fm",   32'(fm_a),   FM_EN ? 32'hFF : 32'h0);

    // T4: start mid-sweep is ignored
    mode_a = 0;
    run(1'b0, 24, 10, "T4");
    check("T4_pass", 32'(pass_a), 1);
    check("T4_err",  32'(err_a),  0);

    // T5: faulty sweep interrupted by reset at cycle 12, then a clean sweep
    mode_a = 1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (12) @(negedge clk);
    check("T5_busy_mid", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    check_zero_a("T5R");
    @(negedge clk);
    check_zero_a("T5H");
    rst_n  = 1'b1;
    mode_a = 0;
    run(1'b0, 24, -1, "T5");
    check("T5_pass", 32'(pass_a), 1);
    check("T5_err",  32'(err_a),  0);
    check("T5_ff",   32'(ff_a),   0);

    // T6: SETTLE=0, faulty sweep then restart from DONE with a correct DUT
    mode_b = 2;
    run(1'b1, 16, -1, "T6F");
    check("T6F_err",  32'(err_b),  8);
    check("T6F_pass", 32'(pass_b), 0);
    mode_b = 0;
    run(1'b1, 16, -1, "T6");
    check("T6_pass", 32'(pass_b), 1);
    check("T6_err",  32'(err_b),  0);
    check("T6_fm",   32'(fm_b),   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
